// File: rtl/uart_echo_checker.sv
// UART initiator/checker: sends seed+k bytes over 8N1, waits for each echo and
// scores it against the uppercase conversion, counting mismatches, framing errors and timeouts.
module uart_echo_checker #(
  parameter int CLK_FREQ       = 12000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_count,
  input  logic [7:0] i_seed,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_err_count,
  output logic       o_timeout,
  output logic [7:0] o_last_rx
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0, S_SEND = 3'd1, S_WAIT = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4;
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

  // ---------------- receiver ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_done_q, rx_ferr_q;
  logic [1:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q, last_rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_st_q   <= R_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0;
      rx_sh_q   <= '0; last_rx_q <= '0; rx_done_q <= 1'b0; rx_ferr_q <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_done_q <= 1'b0;
      case (rx_st_q)
        R_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_st_q  <= R_START;
          rx_cnt_q <= '0;
        end
        R_START: if (rx_cnt_q == HALF_M1) begin
          // a start bit that is high again at mid-bit was only a glitch
          rx_st_q  <= rx_sync_q ? R_IDLE : R_DATA;
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        R_DATA: if (rx_cnt_q == CPB_M1) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        R_STOP: if (rx_cnt_q == CPB_M1) begin
          rx_cnt_q  <= '0;
          rx_st_q   <= R_IDLE;
          rx_done_q <= 1'b1;
          rx_ferr_q <= !rx_sync_q;
          last_rx_q <= rx_sh_q;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- sequencer + transmitter ----------------
  logic [2:0]    state_q, state_d;
  logic [7:0]    count_q, count_d, seed_q, seed_d, k_q, k_d, err_q, err_d;
  logic          pass_q, pass_d, tmo_q, tmo_d, chk_to_q, chk_to_d, chk_fe_q, chk_fe_d, tx_q, tx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    cur_byte, nxt_byte, exp_byte;
  logic [9:0]    frame_d;

  assign cur_byte = seed_q + k_q;
  assign exp_byte = (cur_byte >= 8'h61 && cur_byte <= 8'h7A) ? cur_byte - 8'h20 : cur_byte;
  assign nxt_byte = seed_d + k_d;
  assign frame_d  = {1'b1, nxt_byte, 1'b0};

  always_comb begin
    state_d  = state_q;  count_d  = count_q;  seed_d = seed_q;  k_d = k_q;
    err_d    = err_q;    pass_d   = pass_q;   tmo_d  = tmo_q;
    chk_to_d = chk_to_q; chk_fe_d = chk_fe_q;
    tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q; to_cnt_d = to_cnt_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        count_d = i_count; seed_d = i_seed; k_d = '0;
        err_d = '0; tmo_d = 1'b0; pass_d = 1'b0;
        tx_cnt_d = '0; tx_bit_d = '0;
        state_d = (i_count == 8'd0) ? S_DONE : S_SEND;
      end
      S_SEND: if (tx_cnt_q == CPB_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_bit_d = '0;
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end else tx_bit_d = tx_bit_q + 4'd1;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_WAIT: begin
        if (rx_done_q) begin
          chk_fe_d = rx_ferr_q;
          chk_to_d = 1'b0;
          state_d  = S_CHECK;
        end else if (rx_st_q != R_IDLE) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_M1) begin
          chk_to_d = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_CHECK;
        end else to_cnt_d = to_cnt_q + TW'(1);
      end
      S_CHECK: begin
        if (chk_to_q || chk_fe_q || last_rx_q != exp_byte)
          err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        k_d     = k_q + 8'd1;
        state_d = ((k_q + 8'd1) == count_q) ? S_DONE : S_SEND;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // result is settled on the way into DONE so it already covers the last CHECK
    if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == 8'd0);
    tx_d = (state_d == S_SEND) ? frame_d[tx_bit_d] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE; count_q <= '0; seed_q <= '0; k_q <= '0; err_q <= '0;
      pass_q   <= 1'b0; tmo_q <= 1'b0; chk_to_q <= 1'b0; chk_fe_q <= 1'b0; tx_q <= 1'b1;
      tx_cnt_q <= '0; tx_bit_q <= '0; to_cnt_q <= '0;
    end else begin
      state_q  <= state_d; count_q <= count_d; seed_q <= seed_d; k_q <= k_d; err_q <= err_d;
      pass_q   <= pass_d; tmo_q <= tmo_d; chk_to_q <= chk_to_d; chk_fe_q <= chk_fe_d; tx_q <= tx_d;
      tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; to_cnt_q <= to_cnt_d;
    end
  end

  assign o_tx        = tx_q;
  assign o_busy      = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign o_done      = (state_q == S_DONE);
  assign o_pass      = pass_q;
  assign o_err_count = err_q;
  assign o_timeout   = tmo_q;
  assign o_last_rx   = last_rx_q;
endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench: decodes o_tx frames, plays the far-end converter on i_rx and scores each
// run against a queue-based model of the expected bytes, errors and result flags.
module tb_uart_echo_checker;
  localparam int CLK_FREQ = 800000;
  localparam int BAUD     = 100000;
  localparam int TMO      = 64;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_rx = 1'b1;
  logic [7:0] i_count = '0, i_seed = '0;
  logic       o_tx, o_busy, o_done, o_pass, o_timeout;
  logic [7:0] o_err_count, o_last_rx;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_echo_checker #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_count(i_count), .i_seed(i_seed),
    .o_tx(o_tx), .i_rx(i_rx), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_count(o_err_count), .o_timeout(o_timeout), .o_last_rx(o_last_rx)
  );

  logic [7:0] tx_q[$];
  logic [7:0] echo_q[$];
  int         tx_stop_bad = 0;
  int         echo_mode = 0;   // 0: uppercase, 1: unconverted, 2: silent
  int         bad_idx = -1;
  int         echo_idx = 0;
  bit         echo_en = 1'b1;
  logic [7:0] last_sent = '0;

  function automatic logic [7:0] upcase(input logic [7:0] b);
    if (b >= "a" && b <= "z") return b - 8'h20;
    return b;
  endfunction

  // o_tx frame decoder
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        if (o_tx !== 1'b1) tx_stop_bad++;
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
        tx_q.push_back(b);
        echo_q.push_back(b);
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stopv);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stopv;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
  endtask

  // far-end converter model
  initial begin : echo
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (echo_q.size() > 0) begin
        b = echo_q.pop_front();
        if (echo_en && echo_mode != 2) begin
          e = (echo_mode == 0) ? upcase(b) : b;
          repeat ($urandom_range(1, 10)) @(negedge clk);
          last_sent = e;
          send_rx(e, (echo_idx != bad_idx));
        end
        echo_idx++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic run_check(input string name, input logic [7:0] seed, input logic [7:0] cnt,
                           input int mode, input int bidx, input bit mid_start, output int lat);
    int exp_err, bound;
    logic [7:0] b;
    echo_mode = mode; bad_idx = bidx; echo_idx = 0; tx_q.delete(); tx_stop_bad = 0;
    exp_err = 0;
    for (int k = 0; k < int'(cnt); k++) begin
      b = 8'(seed + k);
      if (mode == 2 || k == bidx || (mode == 1 && upcase(b) != b)) exp_err++;
    end
    if (exp_err > 255) exp_err = 255;
    bound = int'(cnt) * (20 * CPB + TMO + 40) + 20;
    @(negedge clk);
    i_seed = seed; i_count = cnt; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    n_tests++;
    if (cnt != 0 && o_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
    end
    while (o_done !== 1'b1 && lat < bound) begin
      i_start = (mid_start && lat == 20);
      if (mid_start && lat == 20) begin i_seed = ~seed; i_count = cnt + 8'd3; end
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    n_tests++;
    if (o_done !== 1'b1) begin
      n_fail++; $display("FAIL %s done: not seen within %0d cycles", name, bound);
    end
    n_tests++;
    if (tx_q.size() != int'(cnt)) begin
      n_fail++; $display("FAIL %s tx_frames: got %0d expected %0d", name, tx_q.size(), cnt);
    end
    for (int k = 0; k < int'(cnt) && k < tx_q.size(); k++) begin
      n_tests++;
      if (tx_q[k] !== 8'(seed + k)) begin
        n_fail++; $display("FAIL %s tx_byte[%0d]: got %02h expected %02h", name, k, tx_q[k], 8'(seed + k));
      end
    end
    n_tests++;
    if (tx_stop_bad != 0) begin
      n_fail++; $display("FAIL %s tx_stop: got %0d bad stop bits expected 0", name, tx_stop_bad);
    end
    n_tests++;
    if (o_err_count !== 8'(exp_err)) begin
      n_fail++; $display("FAIL %s err_count: got %0d expected %0d", name, o_err_count, exp_err);
    end
    n_tests++;
    if (o_pass !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s pass: got %b expected %b", name, o_pass, (exp_err == 0));
    end
    n_tests++;
    if (o_timeout !== (mode == 2 && cnt != 0)) begin
      n_fail++; $display("FAIL %s timeout: got %b expected %b", name, o_timeout, (mode == 2 && cnt != 0));
    end
    n_tests++;
    if (o_last_rx !== last_sent) begin
      n_fail++; $display("FAIL %s last_rx: got %02h expected %02h", name, o_last_rx, last_sent);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", name, o_busy);
    end
    @(negedge clk);
    n_tests++;
    if (o_done !== 1'b0 || o_pass !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s after_done: got done=%b pass=%b expected done=0 pass=%b",
                         name, o_done, o_pass, (exp_err == 0));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
        o_err_count !== 8'd0 || o_timeout !== 1'b0 || o_last_rx !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: got tx=%b busy=%b done=%b pass=%b err=%0d tmo=%b last=%02h expected 1 0 0 0 0 0 00",
               o_tx, o_busy, o_done, o_pass, o_err_count, o_timeout, o_last_rx);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_check("basic", 8'h61, 8'd3, 0, -1, 1'b0, lat);
    n_tests++;
    if (o_last_rx !== 8'h43) begin
      n_fail++; $display("FAIL basic last_rx_const: got %02h expected 43", o_last_rx);
    end
  endtask

  task automatic test_unconverted();
    int lat;
    run_check("unconverted", 8'h61, 8'd2, 1, -1, 1'b0, lat);
  endtask

  task automatic test_count_zero();
    int tx_hi;
    @(negedge clk);
    i_count = 8'd0; i_seed = 8'($urandom); i_start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_busy !== 1'b0 || o_err_count !== 8'd0) begin
      n_fail++; $display("FAIL count_zero done: got done=%b pass=%b busy=%b err=%0d expected 1 1 0 0",
                         o_done, o_pass, o_busy, o_err_count);
    end
    // start still held high during DONE must be ignored
    @(negedge clk);
    i_start = 1'b0;
    tx_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_done === 1'b0 && o_busy === 1'b0 && o_tx === 1'b1) tx_hi++;
      @(negedge clk);
    end
    n_tests++;
    if (tx_hi != 6) begin
      n_fail++; $display("FAIL count_zero idle_after: got %0d idle cycles expected 6", tx_hi);
    end
  endtask

  task automatic test_timeout();
    int lat, exp_lat;
    exp_lat = 2 * (10 * CPB + TMO + 1) + 1;
    run_check("timeout", 8'($urandom), 8'd2, 2, -1, 1'b0, lat);
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL timeout latency: got %0d expected %0d", lat, exp_lat);
    end
  endtask

  task automatic test_wrap();
    int lat;
    run_check("wrap", 8'hFE, 8'd4, 0, -1, 1'b0, lat);
  endtask

  task automatic test_bad_stop_mid_start();
    int lat;
    run_check("bad_stop", 8'h61, 8'd3, 0, 1, 1'b1, lat);
  endtask

  task automatic test_random();
    int lat, cnt, mode, bidx;
    for (int r = 0; r < 5; r++) begin
      cnt  = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      bidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, cnt - 1);
      run_check($sformatf("random%0d", r), 8'($urandom), 8'(cnt), mode, bidx, 1'b0, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    i_seed = 8'h70; i_count = 8'd3; echo_mode = 0; bad_idx = -1; echo_idx = 0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    echo_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_err_count !== 8'd0 || o_last_rx !== 8'd0 || o_pass !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got tx=%b busy=%b err=%0d last=%02h pass=%b expected 1 0 0 00 0",
                         o_tx, o_busy, o_err_count, o_last_rx, o_pass);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tx_q.delete(); echo_q.delete();
    last_sent = '0;
    echo_en = 1'b1;
    run_check("after_reset", 8'($urandom), 8'd2, 0, -1, 1'b0, lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unconverted();
    test_count_zero();
    test_timeout();
    test_wrap();
    test_bad_stop_mid_start();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- UART initiator and checker for the far end of the lowercase-to-uppercase echo link.
- Transmits a generated byte sequence over 8N1 serial. After each byte, waits for the echoed byte, compares it against the expected uppercase conversion and tallies errors.
- Contains its own bit-level transmitter, receiver and baud timing.
- Used as an on-chip self-test and as the bench-side driver for the converter.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (104 at the defaults).
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for an echo start bit after the TX stop bit ends.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse that starts a run. Sampled only in IDLE.
- i_count  input  8  number of bytes in the run. Latched at start.
- i_seed  input  8  first byte of the pattern. Latched at start.
- o_tx  output  1  serial output. Idles high.
- i_rx  input  1  serial input carrying the echo. Asynchronous.
- o_busy  output  1  high from the cycle after an accepted start until DONE.
- o_done  output  1  one-cycle pulse at the end of a run.
- o_pass  output  1  run result, valid from o_done until the next accepted start.
- o_err_count  output  8  mismatches, framing errors and timeouts. Saturates at 255.
- o_timeout  output  1  sticky per run. Set if any echo timed out.
- o_last_rx  output  8  most recently received echo byte.

Behaviour:
- Reset (asynchronous, immediate):
  - o_tx=1; o_busy=0, o_done=0, o_pass=0, o_err_count=0, o_timeout=0, o_last_rx=0.
  - FSM returns to IDLE; all counters are cleared.
- Pattern: byte k = (seed + k) mod 256, k = 0..count-1, with 8-bit wrap.
- Expected echo: if the byte is 0x61..0x7A, expected = byte - 0x20; otherwise expected = byte.
- FSM states: IDLE, SEND, WAIT_ECHO, CHECK, DONE.
  - IDLE:
    - On i_start, latch count and seed, clear o_err_count, o_timeout and o_pass.
    - If count=0, go to DONE. Otherwise go to SEND.
  - SEND:
    - o_tx drives the start bit (0) in the first SEND cycle.
    - Then 8 data bits, LSB first, then the stop bit (1), each held exactly CLKS_PER_BIT cycles.
    - After the stop bit completes, go to WAIT_ECHO.
  - WAIT_ECHO:
    - Timeout counter runs; it is cleared when a start bit is detected.
    - On a complete received frame, go to CHECK.
    - If the counter reaches TIMEOUT_CYCLES with no start bit: increment err, set o_timeout, then advance as in CHECK without a compare.
  - CHECK (1 cycle):
    - Compare the received byte against expected. A mismatch or a framing error increments err.
    - Increment k. If k == count, go to DONE; otherwise go to SEND.
  - DONE (1 cycle):
    - o_done=1 and o_busy=0.
    - o_pass = (err==0), computed including any increment made in the preceding CHECK.
    - Return to IDLE.
- Receiver:
  - i_rx passes through a 2-flop synchronizer.
  - A falling edge in the idle state starts the bit timer.
  - The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, treat it as a glitch and return to idle.
  - Data bits are sampled at mid-bit.
  - Stop bit sampled low = framing error. o_last_rx is still updated.
  - The receiver runs in all states. Frames completing outside WAIT_ECHO update o_last_rx only and are not counted or compared.
- o_err_count saturates at 255 and does not wrap.
- i_start while o_busy=1 is ignored. i_start in the same cycle as DONE is ignored.
- Per-byte minimum latency: 10*CLKS_PER_BIT TX cycles, plus echo arrival, plus 1 CHECK cycle.

Test Plan:
- count=3, seed=0x61, bench echoes the uppercase conversion → o_tx frames 0x61, 0x62, 0x63; o_done pulse; o_pass=1, o_err_count=0, o_last_rx=0x43.
- count=2, seed=0x61, bench echoes bytes unconverted → o_err_count=2, o_pass=0, o_timeout=0.
- count=2, i_rx tied high → two timeouts; o_timeout=1, o_err_count=2, o_pass=0; o_done ≈ 2*(10*104+4096+1)+1 cycles after start.
- count=4, seed=0xFE, correct echo → transmitted bytes 0xFE, 0xFF, 0x00, 0x01 (wrap); o_pass=1.
- count=0 → o_done one cycle after the start cycle, o_pass=1, o_tx constantly 1.
- Echo with stop bit 0 → err+1. Second i_start mid-run → ignored. rst_n low mid-frame → o_tx=1 and o_busy=0 immediately; a new start then succeeds.
